// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of up to wwd unit results per cycle,
// same-cycle claim back to the units, registered writeback one cycle later.
package wb_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] npc;
    logic [6:0]  prda;
    logic [31:0] prdv;
  } exe_bundle_t;
endpackage

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int nfu = 4,
  parameter int ewd = 4,
  parameter int wwd = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  exe_bundle_t [nfu-1:0][ewd-1:0]    fu_resp,
  output logic        [nfu-1:0][ewd-1:0]    fu_claim,
  output exe_bundle_t [wwd-1:0]             wb,
  output logic        [$clog2(wwd):0]       wb_cnt,
  output logic        [63:0]                grant_total
);

  localparam int N  = nfu * ewd;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(wwd) + 1;

  exe_bundle_t [N-1:0]   w_flat;
  logic        [N-1:0]   w_claim;
  exe_bundle_t [wwd-1:0] w_nxt_wb;
  logic        [CW-1:0]  w_g;
  logic        [PW-1:0]  w_ptr_nxt;
  logic                  w_act;

  exe_bundle_t [wwd-1:0] r_wb;
  logic        [CW-1:0]  r_cnt;
  logic        [PW-1:0]  r_ptr;
  logic        [63:0]    r_total;

  assign w_flat = fu_resp;
  assign w_act  = rst & ~flush;

  // Walk lanes from r_ptr with modulo-N wrap, taking the first wwd valid ones.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] k;
    w_claim   = '0;
    w_nxt_wb  = '0;
    w_g       = '0;
    w_ptr_nxt = r_ptr;
    for (int j = 0; j < N; j++) begin
      sum = {1'b0, r_ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      k = sum[PW-1:0];
      if (w_flat[k].opid[15] && (int'(w_g) < wwd)) begin
        w_claim[k] = 1'b1;
        for (int i = 0; i < wwd; i++)
          if (w_g == CW'(i))
            w_nxt_wb[i] = w_flat[k];
        w_g = w_g + 1'b1;
        w_ptr_nxt = (k == PW'(N - 1)) ? '0 : k + 1'b1;
      end
    end
  end

  assign fu_claim = w_act ? w_claim : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb    <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_total <= '0;
    end else if (flush) begin
      r_wb  <= '0;
      r_cnt <= '0;
      r_ptr <= '0;
    end else begin
      r_wb    <= w_nxt_wb;
      r_cnt   <= w_g;
      r_ptr   <= w_ptr_nxt;
      r_total <= r_total + 64'(w_g);
    end
  end

  assign wb          = r_wb;
  assign wb_cnt      = r_cnt;
  assign grant_total = r_total;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execution units (ALU, MUL, LSU, …) and the physical register file / ROB completion logic. Each cycle it scans the result lanes presented by all functional units, grants up to `wwd` valid results in round-robin order, and asserts the matching `claim` bits so each unit pops them that same cycle. Granted results are registered onto the writeback ports one cycle later. Ungranted results stay held by their units until a later grant.

## Interface
Parameters:
- `nfu`, 4: number of functional units attached.
- `ewd`, 4: result lanes per functional unit, matching the units' `resp`/`claim` width.
- `wwd`, 2: writeback ports, which is the maximum number of grants per cycle. Constraint: 1 ≤ `wwd` ≤ `nfu*ewd`.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset. State resets on a rising edge while `rst`=0.
- `flush`  in  1: pipeline flush, synchronous, active-high.
- `fu_resp`  in  `nfu*ewd` × `$bits(exe_bundle_t)`: unit results, indexed `[fu][lane]`. A lane is valid when `opid[15]`=1.
- `fu_claim`  out  `nfu*ewd`: combinational grant/pop back to the units, indexed `[fu][lane]`.
- `wb`  out  `wwd` × `$bits(exe_bundle_t)`: registered writeback results. A port is valid when `opid[15]`=1.
- `wb_cnt`  out  `$clog2(wwd)+1`: registered count of valid `wb` ports, which are always packed from port 0.
- `grant_total`  out  64: registered count of all results granted since reset.

## Operation
- Flattened lane index: `k = fu*ewd + lane`, with `N = nfu*ewd` lanes in total.
- Round-robin pointer `ptr` has width `$clog2(N)` and range 0..N-1.
- Scan order: `ptr, ptr+1, …, N-1, 0, …, ptr-1`, wrapping modulo N. This holds even when N is not a power of 2.
- Grant rule: the first `g = min(wwd, number of valid lanes)` valid lanes in scan order are granted.
  - `fu_claim[k]` = 1 exactly for the granted lanes. All other claim bits are 0.
  - Claim bits never assert on an invalid lane.
- Packing: the i-th granted lane in scan order goes to `wb[i]` on the next edge. Ports `g..wwd-1` load all zeros. `wb_cnt` loads `g`.
- Pointer update:
  - If `g` > 0, `ptr` loads `(last granted k + 1) mod N`.
  - If `g` = 0, `ptr` holds.
- `grant_total` increments by `g` every cycle and wraps silently at 2^64.
- Flush, with `rst`=1 and `flush`=1:
  - `fu_claim` is forced to 0 that cycle.
  - `wb` and `wb_cnt` load 0.
  - `ptr` loads 0.
  - `grant_total` holds.
  - Units drop their own contents on flush, so nothing is lost.
- Reset (`rst`=0) has priority over flush:
  - `fu_claim` is forced to 0.
  - `wb`, `wb_cnt`, `ptr` and `grant_total` all load 0.
- Results pass through unmodified. The arbiter does not inspect `npc`, `prda` or `prdv`.

## Timing
- Claim path: `fu_resp` → `fu_claim` is combinational and lands in the same cycle. Units pop on the same edge on which the arbiter captures the result.
- Latency: 1 cycle from a result being granted to it appearing on `wb`.
- No backpressure: the `wb` consumer must accept all `wwd` ports every cycle.
- Reset values: `wb`=0, `wb_cnt`=0, `grant_total`=0, `ptr`=0. `fu_claim`=0 while `rst`=0.
- Held lanes: a valid lane that is not granted must be presented unchanged next cycle. This is the unit's obligation. Round-robin fairness bounds its wait to ⌈N/wwd⌉ cycles.
- Simultaneous events:
  - When `flush` and valid lanes occur in the same cycle, there are no grants.
  - A lane that becomes valid in the same cycle as `ptr` moves past it waits a full rotation in the worst case.
- Pointer wrap: if the last grant is at `k`=N-1, `ptr` loads 0.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with all lanes valid. Required: `fu_claim`=0, `wb`=0, `wb_cnt`=0 and `grant_total`=0 throughout. On the first cycle after release, with `ptr`=0, lanes 0 and 1 are claimed.
- **Round-robin** (`nfu`=4, `ewd`=4, `wwd`=2): all 16 lanes valid continuously.
  - Claims must be {0,1}, {2,3}, …, {14,15}, then {0,1} again.
  - `grant_total` increases by 2 per cycle.
- **Sparse/wrap:** `ptr`=14, with only lanes 15, 3 and 9 valid.
  - Required: claim {15,3}. Next cycle `wb[0]`=lane 15 data, `wb[1]`=lane 3 data, `wb_cnt`=2, and `ptr`=4.
  - The following cycle lane 9 is granted alone: `wb_cnt`=1 and `wb[1]`=0.
- **Idle:** no valid lanes for 5 cycles. Required: `fu_claim`=0, `wb_cnt`=0, and both `ptr` and `grant_total` unchanged.
- **Flush:** assert `flush` while 3 lanes are valid and `wb_cnt`=2.
  - Required: `fu_claim`=0 that cycle. Next cycle `wb`=0, `wb_cnt`=0 and `ptr`=0, with `grant_total` unchanged.
  - Reset taking priority over flush is checked by asserting `rst`=0 and `flush`=1 together, which must clear `grant_total`.
- **MUL integration:** a MUL unit on fu 1 produces 6 back-to-back results while the ALU saturates fu 0.
  - All 6 MUL opids must appear on `wb` exactly once and in order.
  - No MUL result waits more than ⌈16/2⌉=8 cycles after becoming valid.
